tlul_arbiter: RTL and testbench
===============================

TLUL_ARBITER -- requirements
Module: tlul_arbiter

Interface
REQ-001 SHALL have parameter NHOST, default 2, number of TL-UL hosts sharing one device port (2..8).
REQ-002 SHALL have parameter DEPTH, default 4, max outstanding A-requests awaiting a D-response (power of 2, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port host_i  input  NHOST x tl_m2s_t  host requests and D-channel ready.
REQ-006 SHALL have port host_o  output  NHOST x tl_s2m_t  per-host responses and A-channel ready.
REQ-007 SHALL have port dev_o  output  tl_m2s_t  request to shared device.
REQ-008 SHALL have port dev_i  input  tl_s2m_t  device response.
REQ-009 SHALL have port err_o  output  1  sticky flag: D-beat received with no outstanding request.

Function
REQ-010 SHALL run A-channel FSM with states IDLE and HOLD.
REQ-011 In IDLE, SHALL pick winner among hosts with a_valid=1 by round-robin: search starts at rr_ptr+1 mod NHOST.
REQ-012 SHALL drive dev_o A fields from winner, same cycle (zero-latency combinational path), and dev_o.a_valid=1 only if a host requests and tracking FIFO not full.
REQ-013 SHALL assert host_o[w].a_ready = dev_i.a_ready for winner w only; all other hosts a_ready=0.
REQ-014 On A handshake (dev_o.a_valid & dev_i.a_ready): push w into FIFO, set rr_ptr=w, remain/return IDLE.
REQ-015 IDLE with dev_o.a_valid=1 and dev_i.a_ready=0: latch w, go HOLD.
REQ-016 In HOLD, SHALL forward only latched host regardless of other requests; return to IDLE on handshake.
REQ-017 When FIFO full: dev_o.a_valid=0, all host a_ready=0; push gated by full even if a pop occurs same cycle.
REQ-018 FIFO entry width SHALL be clog2(NHOST) bits; count width clog2(DEPTH)+1; pointers wrap mod DEPTH.
REQ-019 D-channel: FIFO head h selects route; host_o[h] D fields = dev_i D fields, d_valid = dev_i.d_valid; other hosts d_valid=0; dev_o.d_ready = host_i[h].d_ready.
REQ-020 On D handshake SHALL pop FIFO; simultaneous push and pop SHALL leave count unchanged.
REQ-021 dev_i.d_valid=1 with FIFO empty: dev_o.d_ready=1 (beat dropped), err_o set, held until reset.
REQ-022 Device SHALL be required to respond in request order; no source remapping; a_source passes unchanged.

Reset
REQ-023 On rst_i: FSM=IDLE, FIFO empty, rr_ptr=NHOST-1 (host 0 first), err_o=0.
REQ-024 Under reset: dev_o.a_valid=0, dev_o.d_ready=0, all host a_ready=0, all host d_valid=0.
REQ-025 Reset mid-transaction SHALL discard all outstanding entries and any HOLD latch immediately.

Configuration
REQ-026 Macro TLUL_ARB_FIXED_PRIO_EN defined: IDLE winner = lowest-index requesting host; rr_ptr unused.
REQ-027 Macro undefined: round-robin per REQ-011; all other behaviour identical.

Structure
REQ-028 tl_m2s_t/tl_s2m_t and opcode enums SHALL come from TileLinkUL_pkg; widths from Default_pkg; no new typedefs in the block.
REQ-029 Outstanding tracker SHALL be sub-module tlul_arb_fifo (sync FIFO, params WIDTH, DEPTH, ports push/pop/data/full/empty).

Verification
REQ-030 Hosts 0,1 both a_valid continuously, device always ready: grants alternate 0,1,0,1; D beats routed in same order.
REQ-031 Host 1 alone a_valid, device a_ready low 3 cycles, host 0 raises a_valid in cycle 2: dev_o stays on host 1 (HOLD) until handshake, host 0 granted next.
REQ-032 DEPTH=4, device never issues D: exactly 4 A handshakes, then dev_o.a_valid=0 and host a_ready=0; one D beat -> a fifth handshake allowed.
REQ-033 FIFO full, D handshake and pending request same cycle: pop only, count 4->3; push next cycle.
REQ-034 dev_i.d_valid=1 after reset with no request: dev_o.d_ready=1, no host d_valid, err_o=1 next cycle, stays 1.
REQ-035 rst_i asserted with 2 outstanding and HOLD active: all outputs zero, next request from host 0 granted first; with TLUL_ARB_FIXED_PRIO_EN, both hosts requesting -> host 0 every time.

Source files
------------

// File: rtl/Default_pkg.sv
// Default_pkg: bus width defaults shared by the TL-UL type definitions.
package Default_pkg;

  localparam int TL_AW  = 32;          // address width
  localparam int TL_DW  = 32;          // data width
  localparam int TL_AIW = 8;           // A-channel source id width
  localparam int TL_DIW = 1;           // D-channel sink id width
  localparam int TL_SZW = 2;           // size field width
  localparam int TL_DBW = TL_DW / 8;   // byte mask width

endpackage

// File: rtl/TileLinkUL_pkg.sv
// TileLinkUL_pkg: TL-UL opcodes and host-to-device / device-to-host bundles.
package TileLinkUL_pkg;

  import Default_pkg::*;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_m2s_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_s2m_t;

endpackage

// File: rtl/tlul_arbiter_pkg.sv
// tlul_arbiter_pkg: arbiter FSM state encoding and index-width helper.
package tlul_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Bits needed to name one of n hosts (never less than one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlul_arb_fifo.sv
// tlul_arb_fifo: small synchronous FIFO recording which host owns each
// outstanding A-request. Head is read combinationally so the D-channel can
// be routed in the same cycle the response arrives.
module tlul_arb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A push is refused while full even if a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wptr_d = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = do_pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tlul_arbiter.sv
// tlul_arbiter: shares one TL-UL device port among NHOST hosts.
// A-channel: round-robin pick (or fixed priority with TLUL_ARB_FIXED_PRIO_EN),
// held stable while the device stalls. D-channel: responses return in request
// order and are routed using a FIFO of granted host indices.
module tlul_arbiter
  import tlul_arbiter_pkg::*;
  import TileLinkUL_pkg::*;
#(
  parameter int NHOST = 2,
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_m2s_t host_i [NHOST],
  output tl_s2m_t host_o [NHOST],
  output tl_m2s_t dev_o,
  input  tl_s2m_t dev_i,
  output logic    err_o
);

  localparam int IDXW = idx_width(NHOST);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] hold_q, hold_d;
`ifndef TLUL_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0] rr_q, rr_d;
`endif
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] head_idx;
  logic            any_req;
  logic            a_valid;
  logic            a_hs;
  logic            d_hs;
  logic            fifo_full;
  logic            fifo_empty;
  logic            err_q;

  // Winner selection: latched host in HOLD, otherwise arbitrate the requesters.
  // Loops run backwards so the last hit is the first host in search order.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    if (state_q == ARB_HOLD) begin
      win_idx = hold_q;
      any_req = host_i[hold_q].a_valid;
    end else begin
`ifdef TLUL_ARB_FIXED_PRIO_EN
      for (int k = NHOST - 1; k >= 0; k--) begin
        if (host_i[k].a_valid) begin
          win_idx = IDXW'(k);
          any_req = 1'b1;
        end
      end
`else
      for (int k = NHOST; k >= 1; k--) begin
        if (host_i[(int'(rr_q) + k) % NHOST].a_valid) begin
          win_idx = IDXW'((int'(rr_q) + k) % NHOST);
          any_req = 1'b1;
        end
      end
`endif
    end
  end

  assign a_valid = any_req & ~fifo_full & ~rst_i;
  assign a_hs    = a_valid & dev_i.a_ready;
  assign d_hs    = dev_i.d_valid & ~fifo_empty & host_i[head_idx].d_ready & ~rst_i;

  // Device request: winner's A fields pass straight through; D-ready follows
  // the head owner, or is forced high to drain stray beats when nothing is owed.
  always_comb begin
    dev_o         = host_i[win_idx];
    dev_o.a_valid = a_valid;
    dev_o.d_ready = fifo_empty ? 1'b1 : host_i[head_idx].d_ready;
    if (rst_i) begin
      dev_o = '0;
    end
  end

  // Per-host responses: D payload broadcast, valid/ready steered to one host.
  genvar gi;
  for (gi = 0; gi < NHOST; gi++) begin : g_host
    tl_s2m_t rsp;
    // Build this host's response bundle.
    always_comb begin
      rsp         = dev_i;
      rsp.a_ready = dev_i.a_ready & a_valid & (win_idx == IDXW'(gi));
      rsp.d_valid = dev_i.d_valid & ~fifo_empty & (head_idx == IDXW'(gi));
      if (rst_i) begin
        rsp = '0;
      end
    end
    assign host_o[gi] = rsp;
  end

  // A-channel FSM next state: latch the winner when the device stalls.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
`ifndef TLUL_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (a_hs) begin
`ifndef TLUL_ARB_FIXED_PRIO_EN
          rr_d = win_idx;
`endif
        end else if (a_valid) begin
          state_d = ARB_HOLD;
          hold_d  = win_idx;
        end
      end
      ARB_HOLD: begin
        if (a_hs) begin
          state_d = ARB_IDLE;
`ifndef TLUL_ARB_FIXED_PRIO_EN
          rr_d    = win_idx;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM registers; reset points round-robin at the last host so host 0 goes first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      hold_q  <= '0;
`ifndef TLUL_ARB_FIXED_PRIO_EN
      rr_q    <= IDXW'(NHOST - 1);
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
`ifndef TLUL_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Sticky error: a D beat arrived while no request was outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (dev_i.d_valid & fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  tlul_arb_fifo #(
    .WIDTH (IDXW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (a_hs),
    .pop_i   (d_hs),
    .data_i  (win_idx),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_tlul_arbiter.sv
// tb_tlul_arbiter: directed scenarios plus random traffic, every cycle checked
// against a queue-based model of the arbiter's ordering rules.
module tb_tlul_arbiter;
  import Default_pkg::*;
  import TileLinkUL_pkg::*;

  localparam int NHOST = 3;
  localparam int DEPTH = 4;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  tl_m2s_t host_i [NHOST];
  tl_s2m_t host_o [NHOST];
  tl_m2s_t dev_o;
  tl_s2m_t dev_i;
  logic    err_o;

  always #5 clk = ~clk;

  tlul_arbiter #(.NHOST(NHOST), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .host_i (host_i),
    .host_o (host_o),
    .dev_o  (dev_o),
    .dev_i  (dev_i),
    .err_o  (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus knobs
  logic [NHOST-1:0] av_m = '0;
  logic [NHOST-1:0] dr_m = '1;
  logic             dev_ar = 1'b0;
  logic             dev_dv = 1'b0;
  logic [31:0]      dev_dd = '0;

  // reference model state
  int  m_q[$];
  int  m_last;
  bit  m_hold;
  int  m_held;
  bit  m_err;
  int  g_log[$];
  int  d_log[$];

  // last sampled values for scenario-level checks
  logic       last_av, last_dr, last_err;
  logic [7:0] last_src;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply();
    for (int h = 0; h < NHOST; h++) begin
      host_i[h]           = '0;
      host_i[h].a_valid   = av_m[h];
      host_i[h].a_opcode  = Get;
      host_i[h].a_source  = TL_AIW'(16 + h);
      host_i[h].a_address = TL_AW'((h + 1) * 4096);
      host_i[h].a_mask    = '1;
      host_i[h].d_ready   = dr_m[h];
    end
    dev_i          = '0;
    dev_i.a_ready  = dev_ar;
    dev_i.d_valid  = dev_dv;
    dev_i.d_opcode = AccessAckData;
    dev_i.d_data   = dev_dd;
  endtask

  function automatic int pick(input logic [NHOST-1:0] req);
`ifdef TLUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NHOST; i++) if (req[i]) return i;
`else
    for (int off = 1; off <= NHOST; off++) if (req[(m_last + off) % NHOST]) return (m_last + off) % NHOST;
`endif
    return -1;
  endfunction

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    logic [NHOST-1:0] am, dm;
    apply();
    rst = 1'b1;
    #1;
    am = '0; dm = '0;
    for (int h = 0; h < NHOST; h++) begin
      am[h] = host_o[h].a_ready;
      dm[h] = host_o[h].d_valid;
    end
    check("rst_a_valid", dev_o.a_valid, 0);
    check("rst_d_ready", dev_o.d_ready, 0);
    check("rst_a_ready_mask", am, 0);
    check("rst_d_valid_mask", dm, 0);
    check("rst_err", err_o, 0);
    check("rst_dev_o_zero", dev_o == '0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_last = NHOST - 1;
    m_hold = 0;
    m_held = 0;
    m_err  = 0;
    g_log.delete();
    d_log.delete();
    $display("%0t reset applied", $time);
  endtask

  // One clock cycle: drive, check at negedge against the model, advance model.
  task automatic cycle();
    int win, route;
    bit req, exp_av, exp_dr, a_hs, d_hs;
    logic [NHOST-1:0] am, dm, exp_am, exp_dm;
    apply();
    @(negedge clk);
    if (m_hold) begin
      win = m_held;
      req = av_m[m_held];
    end else begin
      win = pick(av_m);
      req = (win >= 0);
    end
    exp_av = req && (m_q.size() < DEPTH);
    route  = (m_q.size() > 0) ? m_q[0] : -1;
    exp_dr = (route < 0) ? 1'b1 : dr_m[route];
    exp_am = '0;
    if (exp_av && dev_ar) exp_am[win] = 1'b1;
    exp_dm = '0;
    if (route >= 0 && dev_dv) exp_dm[route] = 1'b1;
    am = '0; dm = '0;
    for (int h = 0; h < NHOST; h++) begin
      am[h] = host_o[h].a_ready;
      dm[h] = host_o[h].d_valid;
    end
    last_av  = dev_o.a_valid;
    last_dr  = dev_o.d_ready;
    last_err = err_o;
    last_src = dev_o.a_source;
    check("a_valid", dev_o.a_valid, exp_av);
    if (exp_av) check("a_source", dev_o.a_source, 16 + win);
    check("a_ready_mask", am, exp_am);
    check("d_valid_mask", dm, exp_dm);
    check("d_ready", dev_o.d_ready, exp_dr);
    if (route >= 0) check("d_data", host_o[route].d_data, dev_dd);
    check("err", err_o, m_err);
    @(posedge clk);
    #1;
    a_hs = exp_av && dev_ar;
    d_hs = (route >= 0) && dev_dv && exp_dr;
    if (d_hs) begin
      d_log.push_back(route);
      void'(m_q.pop_front());
      $display("%0t D beat -> host %0d data=%08h", $time, route, dev_dd);
    end
    if (route < 0 && dev_dv) begin
      m_err = 1;
      $display("%0t D beat dropped (nothing outstanding)", $time);
    end
    if (a_hs) begin
      m_q.push_back(win);
      m_last = win;
      m_hold = 0;
      g_log.push_back(win);
      $display("%0t A grant host %0d outstanding=%0d", $time, win, m_q.size());
    end else if (exp_av) begin
      m_hold = 1;
      m_held = win;
    end
  endtask

  int exp_rr[4];

  initial begin
`ifdef TLUL_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif
    do_reset();

    // Two hosts requesting continuously, device always ready.
    av_m = 3'b011; dev_ar = 1; dev_dv = 0; dr_m = '1; dev_dd = 32'hA5A5_0001;
    cycle();
    dev_dv = 1;
    for (int i = 0; i < 7; i++) begin
      dev_dd = $urandom;
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      check("s1_grant", g_log[i], exp_rr[i]);
      check("s1_droute", d_log[i], exp_rr[i]);
    end

    // Stall while host 1 is held; host 0 arrives late and must wait.
    do_reset();
    av_m = 3'b010; dev_ar = 0; dev_dv = 0;
    cycle();
    av_m = 3'b011;
    cycle();
    check("s2_hold_src_a", last_src, 17);
    cycle();
    check("s2_hold_src_b", last_src, 17);
    dev_ar = 1;
    cycle();
    cycle();
    check("s2_grants", g_log.size(), 2);
    check("s2_first", g_log[0], 1);
    check("s2_second", g_log[1], 0);

    // Fill the tracker with no responses, then free exactly one slot.
    do_reset();
    av_m = 3'b001; dev_ar = 1; dev_dv = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("s3_full_grants", g_log.size(), 4);
    check("s3_full_av", last_av, 0);
    dev_dv = 1;
    cycle();
    check("s3_pop_cycle_av", last_av, 0);
    check("s3_no_push_on_pop", g_log.size(), 4);
    check("s3_one_pop", d_log.size(), 1);
    dev_dv = 0;
    cycle();
    check("s3_fifth_grant", g_log.size(), 5);

    // Stray D beat right after reset.
    do_reset();
    av_m = '0; dev_dv = 1;
    cycle();
    check("s4_dready", last_dr, 1);
    check("s4_err_before", last_err, 0);
    dev_dv = 0;
    cycle();
    check("s4_err_set", last_err, 1);
    for (int i = 0; i < 3; i++) cycle();
    check("s4_err_sticky", err_o, 1);

    // Reset with two outstanding and the FSM holding a stalled request.
    do_reset();
    av_m = 3'b011; dev_ar = 1; dev_dv = 0;
    cycle();
    cycle();
    dev_ar = 0;
    cycle();
    check("s5_outstanding", m_q.size(), 2);
    do_reset();
    av_m = 3'b011; dev_ar = 1; dev_dv = 0;
    cycle();
    dev_dv = 1;
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 4; i++) check("s5_grant", g_log[i], exp_rr[i]);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      av_m   = NHOST'($urandom_range(0, (1 << NHOST) - 1));
      dr_m   = NHOST'($urandom_range(0, (1 << NHOST) - 1));
      dev_ar = ($urandom_range(0, 3) != 0);
      dev_dv = ($urandom_range(0, 2) == 0);
      dev_dd = $urandom;
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
